// File: rtl/tree_min_compare_solver_pkg.sv
// -----------------------------------------------------------------------------
// tree_min_compare_solver_pkg
// Shared elaboration-time helper for the minimum-finder compare tree.
//   tree_level_width(total, level): number of nodes on a given tree level
//   when level 0 holds `total` channels. Each level halves the count and
//   rounds up, because an odd leftover node passes through to the next level.
// -----------------------------------------------------------------------------
package tree_min_compare_solver_pkg;

  function automatic int tree_level_width(input int total, input int level);
    int n;
    n = total;
    for (int k = 0; k < level; k++) begin
      n = (n + 1) / 2;
    end
    return n;
  endfunction

endpackage

// File: rtl/tree_compare_node.sv
// -----------------------------------------------------------------------------
// tree_compare_node
// Combinational two-input compare node used inside the minimum tree.
// Ports:
//   valid_a, value_a  : first candidate and its qualifier
//   valid_b, value_b  : second candidate and its qualifier
//   valid_out         : set when at least one input is valid
//   value_out         : unsigned minimum of the valid inputs, 0 when none
// -----------------------------------------------------------------------------
module tree_compare_node #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  valid_a,
  input  logic [DATA_WIDTH-1:0] value_a,
  input  logic                  valid_b,
  input  logic [DATA_WIDTH-1:0] value_b,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] value_out
);

  // Select the smaller valid candidate. The data of an invalid input is never
  // routed to the output, so undefined bits on it cannot leak through.
  always_comb begin
    valid_out = 1'b0;
    value_out = {DATA_WIDTH{1'b0}};
    if (valid_a && valid_b) begin
      valid_out = 1'b1;
      // Ties forward value_b; equal values are interchangeable.
      if (value_a < value_b) begin
        value_out = value_a;
      end else begin
        value_out = value_b;
      end
    end else if (valid_a) begin
      valid_out = 1'b1;
      value_out = value_a;
    end else if (valid_b) begin
      valid_out = 1'b1;
      value_out = value_b;
    end else begin
      valid_out = 1'b0;
      value_out = {DATA_WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/tree_min_compare_solver.sv
// -----------------------------------------------------------------------------
// tree_min_compare_solver
// Registered minimum-finder over CHANNEL_COUNT qualified channels plus an
// always-present default (ceiling) candidate. A balanced binary tree of
// tree_compare_node instances reduces the channels; a final root step
// compares against default_value and the winner is registered once.
// Ports:
//   clk           : clock, all state on the rising edge
//   reset_n       : asynchronous active-low reset, clears result to 0
//   default_value : fallback / ceiling candidate, always considered
//   values        : packed channel values, channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valids        : bit i qualifies channel i
//   result        : registered unsigned minimum of the candidate set
// -----------------------------------------------------------------------------
module tree_min_compare_solver
  import tree_min_compare_solver_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int CHANNEL_COUNT = 5
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic [DATA_WIDTH-1:0]               default_value,
  input  logic [DATA_WIDTH*CHANNEL_COUNT-1:0] values,
  input  logic [CHANNEL_COUNT-1:0]            valids,
  output logic [DATA_WIDTH-1:0]               result
);

  localparam int DEPTH = (CHANNEL_COUNT > 1) ? $clog2(CHANNEL_COUNT) : 0;

  // Per-level node storage; level l uses entries [0 : tree_level_width(l)-1],
  // the rest are tied to zero.
  logic                  lvl_valid [0:DEPTH][0:CHANNEL_COUNT-1];
  logic [DATA_WIDTH-1:0] lvl_value [0:DEPTH][0:CHANNEL_COUNT-1];

  logic                  root_valid;
  logic [DATA_WIDTH-1:0] root_value;
  logic [DATA_WIDTH-1:0] next_result;

  genvar c, l, j;

  // Level 0: channels, with invalid data masked to zero at the leaves.
  generate
    for (c = 0; c < CHANNEL_COUNT; c++) begin : g_leaf
      assign lvl_valid[0][c] = valids[c];
      assign lvl_value[0][c] = valids[c] ? values[c*DATA_WIDTH +: DATA_WIDTH]
                                         : {DATA_WIDTH{1'b0}};
    end
  endgenerate

  // Upper levels: pair adjacent nodes; an odd leftover passes through.
  generate
    for (l = 1; l <= DEPTH; l++) begin : g_level
      localparam int PREV = tree_level_width(CHANNEL_COUNT, l - 1);
      localparam int CUR  = tree_level_width(CHANNEL_COUNT, l);
      for (j = 0; j < CHANNEL_COUNT; j++) begin : g_slot
        if (j < CUR) begin : g_used
          if (2 * j + 1 < PREV) begin : g_pair
            tree_compare_node #(
              .DATA_WIDTH (DATA_WIDTH)
            ) u_node (
              .valid_a   (lvl_valid[l-1][2*j]),
              .value_a   (lvl_value[l-1][2*j]),
              .valid_b   (lvl_valid[l-1][2*j+1]),
              .value_b   (lvl_value[l-1][2*j+1]),
              .valid_out (lvl_valid[l][j]),
              .value_out (lvl_value[l][j])
            );
          end else begin : g_pass
            assign lvl_valid[l][j] = lvl_valid[l-1][2*j];
            assign lvl_value[l][j] = lvl_value[l-1][2*j];
          end
        end else begin : g_unused
          assign lvl_valid[l][j] = 1'b0;
          assign lvl_value[l][j] = {DATA_WIDTH{1'b0}};
        end
      end
    end
  endgenerate

  assign root_valid = lvl_valid[DEPTH][0];
  assign root_value = lvl_value[DEPTH][0];

  // Root step: the default acts as a ceiling that wins unless beaten strictly.
  always_comb begin
    next_result = default_value;
    if (root_valid && (root_value < default_value)) begin
      next_result = root_value;
    end else begin
      next_result = default_value;
    end
  end

  // Single output register; the only state in the block.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result <= {DATA_WIDTH{1'b0}};
    end else begin
      result <= next_result;
    end
  end

endmodule

// File: tb/tb_tree_min_compare_solver.sv
// -----------------------------------------------------------------------------
// tb_tree_min_compare_solver
// Directed self-checking bench for tree_min_compare_solver with
// DATA_WIDTH=8, CHANNEL_COUNT=5. Inputs change on the falling edge and
// result is sampled on falling edges, away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_tree_min_compare_solver;

  localparam int DW = 8;
  localparam int CH = 5;

  logic             clk;
  logic             reset_n;
  logic [DW-1:0]    default_value;
  logic [DW*CH-1:0] values;
  logic [CH-1:0]    valids;
  logic [DW-1:0]    result;

  int total;
  int bad;

  tree_min_compare_solver #(
    .DATA_WIDTH    (DW),
    .CHANNEL_COUNT (CH)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .default_value (default_value),
    .values        (values),
    .valids        (valids),
    .result        (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", tag, got, exp);
    end
  endtask

  task automatic set_ch(input int idx, input logic [DW-1:0] v);
    values[idx*DW +: DW] = v;
  endtask

  // Advance n falling edges so the result has settled after an input change.
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    total         = 0;
    bad           = 0;
    reset_n       = 1'b0;
    default_value = 8'h33;
    values        = {(DW*CH){1'b0}};
    valids        = 5'b00000;

    // Held in reset across several rising edges.
    settle(3);
    check("reset_low", result, 8'h00);

    reset_n = 1'b1;
    settle(2);
    check("no_valid_default", result, 8'h33);

    set_ch(0, 8'h22); valids = 5'b00001;
    settle(2);
    check("ch0_below_default", result, 8'h22);

    set_ch(0, 8'h44);
    settle(2);
    check("ch0_above_default", result, 8'h33);

    set_ch(2, 8'h11); set_ch(4, 8'h88); valids = 5'b10101;
    settle(2);
    check("ch024_min", result, 8'h11);

    valids = 5'b10000; default_value = 8'hAA;
    settle(2);
    check("stale_ch2_ignored", result, 8'h88);

    set_ch(0, 8'hFF); set_ch(1, 8'hFE); set_ch(2, 8'hFD);
    set_ch(3, 8'hFC); set_ch(4, 8'hFB);
    valids = 5'b11111; default_value = 8'hFF;
    settle(2);
    check("all_valid_passthru", result, 8'hFB);

    valids = 5'b00000;
    settle(2);
    check("cleared_valids", result, 8'hFF);

    values = {(DW*CH){1'bx}}; default_value = 8'h10;
    settle(2);
    check("x_invalid_default", result, 8'h10);

    set_ch(1, 8'h05); set_ch(3, 8'h05); valids = 5'b01010;
    settle(2);
    check("tie_equal", result, 8'h05);

    set_ch(1, 8'h10); set_ch(3, 8'h20);
    settle(2);
    check("equal_to_default", result, 8'h10);

    // Latency: change just after a rising edge; old value holds until the next edge.
    set_ch(1, 8'h07); valids = 5'b00010;
    settle(2);
    check("pre_latency", result, 8'h07);
    @(posedge clk); #1;
    set_ch(1, 8'h03);
    #2;
    check("latency_hold_old", result, 8'h07);
    @(posedge clk); #1;
    check("latency_one_cycle", result, 8'h03);

    // Mid-stream asynchronous reset between clock edges.
    set_ch(1, 8'h07);
    settle(2);
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_immediate", result, 8'h00);
    settle(2);
    check("async_reset_held", result, 8'h00);
    reset_n = 1'b1;
    settle(1);
    check("reset_recover", result, 8'h07);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
